// File: rtl/i2s_tx_serializer.sv
// Master-side I2S transmit serializer: pulls words from a valid/ready source into two holding
// registers and shifts them onto sd0/sd1, one bit clock after each word-select transition.
module i2s_tx_serializer #(
  parameter int  DATA_WIDTH = 32,
  localparam int BW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_2ch_i,
  input  logic                  cfg_lsb_first_i,
  input  logic [BW-1:0]         cfg_bits_word_i,
  input  logic                  ws_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_ready_o,
  output logic                  sd0_o,
  output logic                  sd1_o,
  output logic                  underrun_o
);

  localparam logic [BW-1:0] MAX_BIT = BW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [DATA_WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic                  hold0_v_q, hold0_v_d, hold1_v_q, hold1_v_d;
  logic                  armed_q, armed_d, ws_q, ws_d, lsb_q, lsb_d;
  logic                  sd0_q, sd0_d, sd1_q, sd1_d, underrun_q, underrun_d;
  logic [BW-1:0]         cnt_q, cnt_d;

  logic                  ws_edge, arm_edge, frame_start, have_data, pop;
  logic [BW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] w0, w1, ld0, ld1, nxt0, nxt1;

  assign fifo_ready_o = cfg_en_i & (~hold0_v_q | (cfg_2ch_i & ~hold1_v_q));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    hold0_v_d  = hold0_v_q;
    hold1_v_d  = hold1_v_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    armed_d    = armed_q;
    lsb_d      = lsb_q;
    cnt_d      = cnt_q;
    sd0_d      = sd0_q;
    sd1_d      = sd1_q;
    underrun_d = 1'b0;
    ws_d       = ws_i;
    w0         = '0;
    w1         = '0;
    ld0        = '0;
    ld1        = '0;
    nxt0       = '0;
    nxt1       = '0;

    ws_edge     = ws_i ^ ws_q;
    arm_edge    = ~armed_q & ws_q & ~ws_i;
    frame_start = cfg_en_i & ((armed_q & ws_edge) | arm_edge);
    have_data   = hold0_v_q & (hold1_v_q | ~cfg_2ch_i);
    pop         = fifo_valid_i & fifo_ready_o;
    shamt       = MAX_BIT - cfg_bits_word_i;

    if (!cfg_en_i) begin
      hold0_v_d = 1'b0;
      hold1_v_d = 1'b0;
      armed_d   = 1'b0;
      cnt_d     = '0;
      sh0_d     = '0;
      sh1_d     = '0;
      sd0_d     = 1'b0;
      sd1_d     = 1'b0;
    end else if (frame_start) begin
      armed_d = 1'b1;
      cnt_d   = cfg_bits_word_i;
      lsb_d   = cfg_lsb_first_i;
      if (have_data) begin
        w0        = hold0_q;
        w1        = cfg_2ch_i ? hold1_q : '0;
        hold0_v_d = 1'b0;
        if (cfg_2ch_i) hold1_v_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
      // MSB-first words are left-justified so the first bit always sits in the top position.
      ld0   = cfg_lsb_first_i ? w0 : (w0 << shamt);
      ld1   = cfg_lsb_first_i ? w1 : (w1 << shamt);
      sh0_d = ld0;
      sh1_d = ld1;
      sd0_d = cfg_lsb_first_i ? ld0[0] : ld0[DATA_WIDTH-1];
      sd1_d = cfg_lsb_first_i ? ld1[0] : ld1[DATA_WIDTH-1];
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - BW'(1);
      nxt0  = lsb_q ? (sh0_q >> 1) : (sh0_q << 1);
      nxt1  = lsb_q ? (sh1_q >> 1) : (sh1_q << 1);
      sh0_d = nxt0;
      sh1_d = nxt1;
      sd0_d = lsb_q ? nxt0[0] : nxt0[DATA_WIDTH-1];
      sd1_d = lsb_q ? nxt1[0] : nxt1[DATA_WIDTH-1];
    end else begin
      sd0_d = 1'b0;
      sd1_d = 1'b0;
    end

    // A pop never coincides with a successful transfer, so the pre-edge valid picks the slot.
    if (pop) begin
      if (!hold0_v_q) begin
        hold0_d   = fifo_data_i;
        hold0_v_d = 1'b1;
      end else begin
        hold1_d   = fifo_data_i;
        hold1_v_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold0_v_q  <= 1'b0;
      hold1_v_q  <= 1'b0;
      armed_q    <= 1'b0;
      ws_q       <= 1'b0;
      lsb_q      <= 1'b0;
      cnt_q      <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      sd0_q      <= 1'b0;
      sd1_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold0_v_q  <= hold0_v_d;
      hold1_v_q  <= hold1_v_d;
      armed_q    <= armed_d;
      ws_q       <= ws_d;
      lsb_q      <= lsb_d;
      cnt_q      <= cnt_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sd0_q      <= sd0_d;
      sd1_q      <= sd1_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: hold data needs no reset; it is only ever read while its valid flag is set.
  always_ff @(posedge clk_i) begin
    hold0_q <= hold0_d;
    hold1_q <= hold1_d;
  end

  assign sd0_o      = sd0_q;
  assign sd1_o      = sd1_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: directed I2S scenarios plus randomized frames,
// compared cycle by cycle against a word-queue reference model.
module tb_i2s_tx_serializer;

  logic        clk_i = 1'b0;
  logic        rstn_i, cfg_en_i, cfg_2ch_i, cfg_lsb_first_i, ws_i;
  logic [4:0]  cfg_bits_word_i;
  logic [31:0] fifo_data_i;
  logic        fifo_valid_i, fifo_ready_o, sd0_o, sd1_o, underrun_o;

  i2s_tx_serializer #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_2ch_i(cfg_2ch_i),
    .cfg_lsb_first_i(cfg_lsb_first_i), .cfg_bits_word_i(cfg_bits_word_i), .ws_i(ws_i),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_ready_o(fifo_ready_o),
    .sd0_o(sd0_o), .sd1_o(sd1_o), .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: words waiting upstream, words held inside the serializer, current half-frame.
  logic [31:0] src[$];
  logic [31:0] held[$];
  bit          m_armed, m_active, m_ur, m_lsb;
  logic        ws_prev;
  logic [31:0] m_w0, m_w1;
  int          m_bits, m_k;
  logic [63:0] cap0 = '0, cap1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input int k, input int bits, input bit lsb);
    int idx;
    idx = lsb ? k : bits - k;
    return w[idx];
  endfunction

  function automatic logic exp_sd(input logic [31:0] w);
    if (!m_active || m_k > m_bits) return 1'b0;
    return exp_bit(w, m_k, m_bits, m_lsb);
  endfunction

  // One clock: present FIFO data, check ready, advance the model, then check outputs after the edge.
  task automatic edge_step();
    int cap_n;
    bit ready_e, fs, pop;
    fifo_valid_i = (src.size() != 0);
    fifo_data_i  = fifo_valid_i ? src[0] : $urandom();
    #2;
    cap_n   = cfg_2ch_i ? 2 : 1;
    ready_e = cfg_en_i && (held.size() < cap_n);
    check("ready", fifo_ready_o, ready_e);
    pop  = ready_e && fifo_valid_i;
    m_ur = 0;
    if (!cfg_en_i) begin
      held.delete();
      m_armed  = 0;
      m_active = 0;
    end else begin
      fs = (m_armed && (ws_i != ws_prev)) || (!m_armed && ws_prev && !ws_i);
      if (fs) begin
        m_armed  = 1;
        m_active = 1;
        m_k      = 0;
        m_bits   = cfg_bits_word_i;
        m_lsb    = cfg_lsb_first_i;
        if (held.size() >= cap_n) begin
          m_w0 = held.pop_front();
          m_w1 = cfg_2ch_i ? held.pop_front() : 32'h0;
        end else begin
          m_w0 = 32'h0;
          m_w1 = 32'h0;
          m_ur = 1;
        end
      end else begin
        m_k++;
      end
    end
    if (pop) held.push_back(src.pop_front());
    ws_prev = ws_i;
    @(posedge clk_i);
    #1;
    check("sd0", sd0_o, exp_sd(m_w0));
    check("sd1", sd1_o, exp_sd(m_w1));
    check("underrun", underrun_o, m_ur);
    cap0 = {cap0[62:0], sd0_o};
    cap1 = {cap1[62:0], sd1_o};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) edge_step();
  endtask

  task automatic half(input logic v, input int n);
    ws_i = v;
    run(n);
  endtask

  task automatic model_reset();
    held.delete();
    m_armed  = 0;
    m_active = 0;
    m_ur     = 0;
    ws_prev  = 1'b0;
    m_k      = 0;
  endtask

  initial begin
    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_2ch_i = 1'b0; cfg_lsb_first_i = 1'b0;
    cfg_bits_word_i = 5'd15; ws_i = 1'b0; fifo_data_i = '0; fifo_valid_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_sd0", sd0_o, 1'b0);
    check("rst_sd1", sd1_o, 1'b0);
    check("rst_underrun", underrun_o, 1'b0);
    check("rst_ready_dis", fifo_ready_o, 1'b0);
    cfg_en_i = 1'b1;
    #1;
    check("rst_ready_en", fifo_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // 1ch MSB-first, 16-bit word queued while ws high: nothing until ws falls.
    ws_i = 1'b1;
    src.push_back(32'h0000A5C3);
    run(4);
    half(1'b0, 16);
    check("t1_sd0_word", cap0[15:0], 16'b1010010111000011);
    run(4);

    // Source empty at the next edge: underrun, then a late word goes out the following half.
    ws_i = 1'b1;
    edge_step();
    check("t4_underrun_pulse", underrun_o, 1'b1);
    src.push_back(32'hFFFF1234);
    run(19);
    half(1'b0, 16);
    check("t4_late_word", cap0[15:0], 16'h1234);
    // 32-bit words truncated by 16-SCK half-frames; bits changed mid-frame take effect next frame.
    cfg_bits_word_i = 5'd31;
    src.push_back(32'hDEADBEEF);
    src.push_back(32'h0F0F0F0F);
    run(4);
    half(1'b1, 16);
    check("t5_trunc_upper", cap0[15:0], 16'b1101111010101101);
    half(1'b0, 16);
    check("t5_next_clean", cap0[15:0], 16'h0F0F);

    // 2ch LSB-first 8-bit words after a flush; rising ws before arming is ignored.
    cfg_en_i = 1'b0;
    run(2);
    cfg_2ch_i = 1'b1; cfg_lsb_first_i = 1'b1; cfg_bits_word_i = 5'd7; cfg_en_i = 1'b1;
    src.push_back(32'h00000081);
    src.push_back(32'h0000003C);
    half(1'b1, 3);
    half(1'b0, 8);
    check("t2_sd0_lsb", cap0[7:0], 8'b10000001);
    check("t2_sd1_lsb", cap1[7:0], 8'b00111100);

    // Drop enable mid-word with both holds full.
    for (int i = 0; i < 4; i++) src.push_back($urandom());
    run(3);
    half(1'b1, 3);
    cfg_en_i = 1'b0;
    edge_step();
    check("t6_sd0_off", sd0_o, 1'b0);
    check("t6_sd1_off", sd1_o, 1'b0);
    check("t6_ready_off", fifo_ready_o, 1'b0);
    cfg_en_i = 1'b1;
    #1;
    check("t6_holds_empty", fifo_ready_o, 1'b1);
    src.delete();
    cfg_en_i = 1'b0;
    run(1);

    // Randomized configurations and half-frame lengths (shorter and longer than the word).
    for (int it = 0; it < 6; it++) begin
      src.delete();
      cfg_en_i = 1'b0;
      run(1);
      cfg_2ch_i       = 1'($urandom_range(0, 1));
      cfg_lsb_first_i = 1'($urandom_range(0, 1));
      cfg_bits_word_i = 5'($urandom_range(0, 31));
      cfg_en_i        = 1'b1;
      for (int w = 0; w < 24; w++) src.push_back($urandom());
      half(1'b1, 2);
      for (int h = 0; h < 10; h++)
        half(~ws_i, $urandom_range(3, int'(cfg_bits_word_i) + 4));
    end

    // Reset mid-frame: outputs clear immediately, re-arm needed afterwards.
    half(~ws_i, 2);
    rstn_i = 1'b0;
    #1;
    check("rst_mid_sd0", sd0_o, 1'b0);
    check("rst_mid_sd1", sd1_o, 1'b0);
    check("rst_mid_underrun", underrun_o, 1'b0);
    model_reset();
    ws_i = 1'b0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    half(1'b1, 6);
    half(1'b0, 12);
    half(1'b1, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
